// File: rtl/im_loader_pkg.sv
// ============================================================================
//  Module      : im_loader_pkg
//  Description : Shared state encoding and IM memory configuration for the
//                boot-time instruction-memory loader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package im_loader_pkg;

    // Memory configuration: IM byte-address width and base of the text region
    localparam int          c_width_im_addr  = 14;
    localparam logic [31:0] c_text_startaddr = 32'h0000_3000;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/im_loader_byte_packer.sv
// ============================================================================
//  Module      : byte_packer
//  Description : Shifts a byte stream into big-endian 32-bit words; flags each
//                completed word combinationally with the 4th byte.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_packer (
    input  logic        clk_m,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  r_lane;
    logic [23:0] r_shift;

    // Only the three older bytes are stored; the 4th completes the word in flight
    assign word       = {r_shift, byte_data};
    assign word_valid = byte_valid & (r_lane == 2'd3);

    always_ff @(posedge clk_m or negedge rst_n) begin
        if (!rst_n) begin
            r_lane  <= 2'd0;
            r_shift <= 24'd0;
        end else if (clear) begin
            r_lane  <= 2'd0;
            r_shift <= 24'd0;
        end else if (byte_valid) begin
            r_lane  <= r_lane + 2'd1;
            r_shift <= {r_shift[15:0], byte_data};
        end
    end

endmodule

`default_nettype wire

// File: rtl/im_loader.sv
// ============================================================================
//  Module      : im_loader
//  Description : Loads a length-prefixed, XOR-checksummed word stream into the
//                instruction memory and holds the CPU until the load succeeds.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module im_loader
    import im_loader_pkg::*;
#(
    parameter int          WIDTH_IM_ADDR  = c_width_im_addr,
    parameter logic [31:0] TEXT_STARTADDR = c_text_startaddr
) (
    input  logic                     clk_m,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    output logic                     in_ready,
    output logic                     im_we,
    output logic [WIDTH_IM_ADDR-3:0] im_addr,
    output logic [31:0]              im_wdata,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic                     cpu_hold,
    output logic [31:0]              load_base
);

    localparam logic [31:0]              c_capacity = 32'(2 ** (WIDTH_IM_ADDR - 2));
    localparam logic [WIDTH_IM_ADDR-2:0] c_wcnt_one = 1;

    state_t                   r_state;
    state_t                   w_state_next;
    logic                     w_hs;
    logic                     w_clear;
    logic                     w_start_ok;
    logic                     w_write;
    logic [31:0]              w_word;
    logic                     w_word_valid;
    logic [WIDTH_IM_ADDR-2:0] w_wcnt_inc;
    logic [WIDTH_IM_ADDR-2:0] r_wcnt;
    logic [WIDTH_IM_ADDR-2:0] r_nwords;
    logic [31:0]              r_csum;

    assign load_base  = TEXT_STARTADDR;
    assign w_hs       = in_valid & in_ready;
    assign w_wcnt_inc = r_wcnt + c_wcnt_one;
    assign w_clear    = (w_state_next != r_state);

    byte_packer u_packer (
        .clk_m      (clk_m),
        .rst_n      (rst_n),
        .clear      (w_clear),
        .byte_valid (w_hs),
        .byte_data  (in_data),
        .word       (w_word),
        .word_valid (w_word_valid)
    );

    always_ff @(posedge clk_m or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_start_ok   = 1'b0;
        w_write      = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    w_start_ok   = 1'b1;
                    w_state_next = ST_LEN;
                end
            end
            ST_LEN: begin
                if (w_word_valid) begin
                    if (w_word > c_capacity)  w_state_next = ST_ERR;
                    else if (w_word == 32'd0) w_state_next = ST_CSUM;
                    else                      w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_word_valid) begin
                    w_write = 1'b1;
                    if (w_wcnt_inc == r_nwords) w_state_next = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (w_word_valid) w_state_next = (w_word == r_csum) ? ST_DONE : ST_ERR;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // All flags are registered decodes of the next state, so nothing reaches
    // an output combinationally from in_valid.
    always_ff @(posedge clk_m or negedge rst_n) begin
        if (!rst_n) begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= 32'd0;
            r_wcnt   <= '0;
            r_nwords <= '0;
            r_csum   <= 32'd0;
        end else begin
            in_ready <= (w_state_next == ST_LEN) || (w_state_next == ST_DATA) ||
                        (w_state_next == ST_CSUM);
            busy     <= (w_state_next == ST_LEN) || (w_state_next == ST_DATA) ||
                        (w_state_next == ST_CSUM);
            done     <= (w_state_next == ST_DONE);
            error    <= (w_state_next == ST_ERR);
            cpu_hold <= (w_state_next != ST_DONE);
            im_we    <= w_write;
            if (w_start_ok) begin
                r_wcnt <= '0;
                r_csum <= 32'd0;
            end
            if ((r_state == ST_LEN) && w_word_valid) begin
                r_nwords <= w_word[WIDTH_IM_ADDR-2:0];
            end
            if (w_write) begin
                im_addr  <= r_wcnt[WIDTH_IM_ADDR-3:0];
                im_wdata <= w_word;
                r_wcnt   <= w_wcnt_inc;
                r_csum   <= r_csum ^ w_word;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_im_loader.sv
// ============================================================================
//  Module      : tb_im_loader
//  Description : Directed self-checking bench for the instruction-memory loader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_im_loader;

    logic        clk_m = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        im_we;
    logic [11:0] im_addr;
    logic [31:0] im_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;
    logic [31:0] load_base;

    int n_cmp = 0;
    int n_bad = 0;

    logic [11:0] q_addr[$];
    logic [31:0] q_data[$];

    always #5 clk_m = ~clk_m;

    im_loader dut (
        .clk_m     (clk_m),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .cpu_hold  (cpu_hold),
        .load_base (load_base)
    );

    always @(negedge clk_m) begin
        if (im_we === 1'b1) begin
            q_addr.push_back(im_addr);
            q_data.push_back(im_wdata);
        end
    end

    task automatic idle_gap(input int gapmax);
        int g;
        g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
        repeat (g) begin @(posedge clk_m); #1; end
    endtask

    // Presents one byte and returns #1 after the edge on which it transferred
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk_m);
        while (in_ready !== 1'b1 && t < 64) begin
            @(negedge clk_m);
            t++;
        end
        if (in_ready !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL in_ready_timeout: in_ready=%b required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk_m);
        #1;
        in_valid = 1'b0;
        in_data  = 8'hA5;
    endtask

    task automatic send_word(input logic [31:0] w, input int gapmax);
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[8*i +: 8]);
            if (i != 0) idle_gap(gapmax);
        end
    endtask

    task automatic do_start(input string name);
        start = 1'b1;
        @(posedge clk_m);
        #1;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL %s_start_busy: got %b want 1", name, busy); end
        n_cmp++;
        if ({done, error} !== 2'b00) begin n_bad++; $display("FAIL %s_start_flags: done/error got %b want 00", name, {done, error}); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL %s_start_ready: got %b want 1", name, in_ready); end
    endtask

    // Full stream: count, up to two data words, checksum; checks each write and the result
    task automatic load_stream(input logic [31:0] n, input logic [31:0] w0, input logic [31:0] w1,
                               input logic [31:0] csum, input int gapmax, input bit mid_start,
                               input bit exp_done, input string name);
        logic [31:0] d;
        q_addr.delete();
        q_data.delete();
        do_start(name);
        send_word(n, gapmax);
        idle_gap(gapmax);
        for (int k = 0; k < int'(n); k++) begin
            d = (k == 0) ? w0 : w1;
            send_word(d, gapmax);
            n_cmp++;
            if (im_we !== 1'b1) begin n_bad++; $display("FAIL %s_we%0d: got %b want 1", name, k, im_we); end
            n_cmp++;
            if (im_addr !== 12'(k)) begin n_bad++; $display("FAIL %s_addr%0d: got %0d want %0d", name, k, im_addr, k); end
            n_cmp++;
            if (im_wdata !== d) begin n_bad++; $display("FAIL %s_wdata%0d: got %h want %h", name, k, im_wdata, d); end
            if (k == 0 && mid_start) begin
                start = 1'b1;
                @(posedge clk_m);
                #1;
                start = 1'b0;
                n_cmp++;
                if ({busy, in_ready, done, error} !== 4'b1100) begin
                    n_bad++;
                    $display("FAIL %s_midstart: busy/ready/done/error got %b want 1100", name, {busy, in_ready, done, error});
                end
            end
            idle_gap(gapmax);
        end
        send_word(csum, gapmax);
        n_cmp++;
        if (done !== exp_done) begin n_bad++; $display("FAIL %s_done: got %b want %b", name, done, exp_done); end
        n_cmp++;
        if (error !== !exp_done) begin n_bad++; $display("FAIL %s_error: got %b want %b", name, error, !exp_done); end
        n_cmp++;
        if (cpu_hold !== !exp_done) begin n_bad++; $display("FAIL %s_cpu_hold: got %b want %b", name, cpu_hold, !exp_done); end
        n_cmp++;
        if ({busy, in_ready} !== 2'b00) begin n_bad++; $display("FAIL %s_idle: busy/ready got %b want 00", name, {busy, in_ready}); end
        @(posedge clk_m);
        #1;
        n_cmp++;
        if (q_addr.size() != int'(n)) begin n_bad++; $display("FAIL %s_nwrites: got %0d want %0d", name, q_addr.size(), n); end
        for (int k = 0; k < q_addr.size() && k < 2; k++) begin
            d = (k == 0) ? w0 : w1;
            n_cmp++;
            if (q_addr[k] !== 12'(k) || q_data[k] !== d) begin
                n_bad++;
                $display("FAIL %s_log%0d: got %0d/%h want %0d/%h", name, k, q_addr[k], q_data[k], k, d);
            end
        end
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk_m);
        #1;
        n_cmp++;
        if ({in_ready, im_we, busy, done, error} !== 5'b0) begin
            n_bad++;
            $display("FAIL reset_flags: ready/we/busy/done/error got %b want 00000", {in_ready, im_we, busy, done, error});
        end
        n_cmp++;
        if (cpu_hold !== 1'b1) begin n_bad++; $display("FAIL reset_cpu_hold: got %b want 1", cpu_hold); end
        n_cmp++;
        if (im_addr !== 12'd0 || im_wdata !== 32'd0) begin n_bad++; $display("FAIL reset_wport: got %0d/%h want 0/0", im_addr, im_wdata); end
        n_cmp++;
        if (load_base !== 32'h0000_3000) begin n_bad++; $display("FAIL load_base: got %h want 00003000", load_base); end
        @(negedge clk_m);
        rst_n = 1'b1;
        repeat (2) @(posedge clk_m);
        #1;
        n_cmp++;
        if ({busy, in_ready, cpu_hold} !== 3'b001) begin n_bad++; $display("FAIL idle_hold: busy/ready/hold got %b want 001", {busy, in_ready, cpu_hold}); end
    endtask

    task automatic test_oversize;
        q_addr.delete();
        q_data.delete();
        do_start("over");
        send_word(32'h0000_1001, 0);
        n_cmp++;
        if ({error, done, busy, in_ready, im_we} !== 5'b10000) begin
            n_bad++;
            $display("FAIL over_result: err/done/busy/ready/we got %b want 10000", {error, done, busy, in_ready, im_we});
        end
        repeat (4) @(posedge clk_m);
        #1;
        n_cmp++;
        if (q_addr.size() != 0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL over_after: writes %0d ready %b want 0 writes ready 0", q_addr.size(), in_ready);
        end
    endtask

    task automatic test_reset_mid;
        do_start("rmid");
        send_word(32'd2, 0);
        send_word(32'h3C08_1234, 0);
        n_cmp++;
        if (im_we !== 1'b1) begin n_bad++; $display("FAIL rmid_first_we: got %b want 1", im_we); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({im_we, busy, in_ready, done, error, cpu_hold} !== 6'b000001) begin
            n_bad++;
            $display("FAIL rmid_async: we/busy/ready/done/err/hold got %b want 000001", {im_we, busy, in_ready, done, error, cpu_hold});
        end
        n_cmp++;
        if (im_addr !== 12'd0 || im_wdata !== 32'd0) begin n_bad++; $display("FAIL rmid_wport: got %0d/%h want 0/0", im_addr, im_wdata); end
        @(negedge clk_m);
        rst_n = 1'b1;
        @(posedge clk_m);
        #1;
        load_stream(32'd2, 32'h3C08_1234, 32'h3508_5678, 32'h0900_444C, 0, 1'b0, 1'b1, "reload");
    endtask

    initial begin
        test_reset();
        load_stream(32'd2, 32'h3C08_1234, 32'h3508_5678, 32'h0900_444C, 0, 1'b0, 1'b1, "good");
        load_stream(32'd2, 32'h3C08_1234, 32'h3508_5678, 32'h0900_444D, 0, 1'b0, 1'b0, "badsum");
        test_oversize();
        load_stream(32'd0, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b1, "zero");
        load_stream(32'd2, 32'h3C08_1234, 32'h3508_5678, 32'h0900_444C, 3, 1'b1, 1'b1, "gaps");
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
